// File: rtl/frame_buffer_manager.sv
// Triple-buffer scheduler: rotates three DDR frame slots between camera writer and HDMI reader,
// and keeps drop/repeat statistics for frame-rate mismatch debug.
module frame_buffer_manager #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [31:0] FRAME_STRIDE = 32'h0002_5800,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_100Mhz,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             wr_frame_done,
    input  logic             rd_frame_start,
    output logic             wr_en,
    output logic [31:0]      wr_base_addr,
    output logic [31:0]      rd_base_addr,
    output logic             rd_frame_valid,
    output logic [CNT_W-1:0] frames_written,
    output logic [CNT_W-1:0] frames_dropped,
    output logic [CNT_W-1:0] frames_repeated
);

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN} state_t;

    state_t     r_state, w_state_nxt;
    logic       w_run;
    logic [1:0] r_wr_idx, r_rd_idx, r_fresh_idx;
    logic [1:0] w_wr_idx_nxt, w_rd_idx_nxt, w_fresh_idx_nxt;
    logic       r_fresh_valid, w_fresh_valid_nxt;
    logic       r_rd_frame_valid, w_rd_frame_valid_nxt;
    logic       r_wr_en;
    logic [31:0] r_wr_base_addr, r_rd_base_addr;
    logic [CNT_W-1:0] r_frames_written, r_frames_dropped, r_frames_repeated;
    logic       w_wd, w_rs;

    function automatic logic [31:0] slot_addr(input logic [1:0] idx);
        case (idx)
            2'd1:    slot_addr = BASE_ADDR + FRAME_STRIDE;
            2'd2:    slot_addr = BASE_ADDR + (FRAME_STRIDE << 1);
            default: slot_addr = BASE_ADDR;
        endcase
    endfunction

    always_ff @(posedge clk_100Mhz) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Events only act in RUN while enabled; the first done in ARM is a partial frame.
    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_ARM;
                ST_ARM:  if (wr_frame_done) w_state_nxt = ST_RUN;
                ST_RUN:  w_run = 1'b1;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_wd = w_run & wr_frame_done;
    assign w_rs = w_run & rd_frame_start;

    always_comb begin
        w_wr_idx_nxt         = r_wr_idx;
        w_rd_idx_nxt         = r_rd_idx;
        w_fresh_idx_nxt      = r_fresh_idx;
        w_fresh_valid_nxt    = r_fresh_valid;
        w_rd_frame_valid_nxt = r_rd_frame_valid;
        if (w_wd && w_rs) begin
            // Just-finished frame goes straight to the reader; the old read slot becomes spare.
            w_rd_idx_nxt         = r_wr_idx;
            w_wr_idx_nxt         = r_fresh_idx;
            w_fresh_idx_nxt      = r_rd_idx;
            w_fresh_valid_nxt    = 1'b0;
            w_rd_frame_valid_nxt = 1'b1;
        end else if (w_wd) begin
            w_wr_idx_nxt      = r_fresh_idx;
            w_fresh_idx_nxt   = r_wr_idx;
            w_fresh_valid_nxt = 1'b1;
        end else if (w_rs && r_fresh_valid) begin
            w_rd_idx_nxt         = r_fresh_idx;
            w_fresh_idx_nxt      = r_rd_idx;
            w_fresh_valid_nxt    = 1'b0;
            w_rd_frame_valid_nxt = 1'b1;
        end
        if (!enable) begin
            w_fresh_valid_nxt    = 1'b0;
            w_rd_frame_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_100Mhz) begin
        if (!rst_n) begin
            r_wr_idx          <= 2'd0;
            r_rd_idx          <= 2'd1;
            r_fresh_idx       <= 2'd2;
            r_fresh_valid     <= 1'b0;
            r_rd_frame_valid  <= 1'b0;
            r_wr_en           <= 1'b0;
            r_wr_base_addr    <= BASE_ADDR;
            r_rd_base_addr    <= BASE_ADDR + FRAME_STRIDE;
            r_frames_written  <= '0;
            r_frames_dropped  <= '0;
            r_frames_repeated <= '0;
        end else begin
            r_wr_idx         <= w_wr_idx_nxt;
            r_rd_idx         <= w_rd_idx_nxt;
            r_fresh_idx      <= w_fresh_idx_nxt;
            r_fresh_valid    <= w_fresh_valid_nxt;
            r_rd_frame_valid <= w_rd_frame_valid_nxt;
            r_wr_en          <= (w_state_nxt != ST_IDLE);
            r_wr_base_addr   <= slot_addr(r_wr_idx);
            r_rd_base_addr   <= slot_addr(r_rd_idx);
            if (w_wd)
                r_frames_written <= r_frames_written + CNT_W'(1);
            if (w_wd && r_fresh_valid)
                r_frames_dropped <= r_frames_dropped + CNT_W'(1);
            if (w_rs && !w_wd && !r_fresh_valid)
                r_frames_repeated <= r_frames_repeated + CNT_W'(1);
        end
    end

    assign wr_en           = r_wr_en;
    assign wr_base_addr    = r_wr_base_addr;
    assign rd_base_addr    = r_rd_base_addr;
    assign rd_frame_valid  = r_rd_frame_valid;
    assign frames_written  = r_frames_written;
    assign frames_dropped  = r_frames_dropped;
    assign frames_repeated = r_frames_repeated;

endmodule

// File: tb/tb_frame_buffer_manager.sv
// Scoreboard bench for frame_buffer_manager: directed pulses, hand-computed snapshots,
// a second instance with 4-bit counters for the wrap check.
module tb_frame_buffer_manager;

    localparam logic [31:0] S  = 32'h0002_5800;
    localparam logic [31:0] S2 = 32'h0004_B000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        wr_frame_done = 1'b0;
    logic        rd_frame_start = 1'b0;
    logic        wr_en, rd_frame_valid;
    logic [31:0] wr_base_addr, rd_base_addr;
    logic [15:0] frames_written, frames_dropped, frames_repeated;
    logic        wr_en4, rd_frame_valid4;
    logic [31:0] wr_base_addr4, rd_base_addr4;
    logic [3:0]  frames_written4, frames_dropped4, frames_repeated4;

    always #5 clk = ~clk;

    frame_buffer_manager dut (
        .clk_100Mhz(clk), .rst_n(rst_n), .enable(enable),
        .wr_frame_done(wr_frame_done), .rd_frame_start(rd_frame_start),
        .wr_en(wr_en), .wr_base_addr(wr_base_addr), .rd_base_addr(rd_base_addr),
        .rd_frame_valid(rd_frame_valid), .frames_written(frames_written),
        .frames_dropped(frames_dropped), .frames_repeated(frames_repeated)
    );

    frame_buffer_manager #(.CNT_W(4)) dut4 (
        .clk_100Mhz(clk), .rst_n(rst_n), .enable(enable),
        .wr_frame_done(wr_frame_done), .rd_frame_start(rd_frame_start),
        .wr_en(wr_en4), .wr_base_addr(wr_base_addr4), .rd_base_addr(rd_base_addr4),
        .rd_frame_valid(rd_frame_valid4), .frames_written(frames_written4),
        .frames_dropped(frames_dropped4), .frames_repeated(frames_repeated4)
    );

    typedef struct {
        string       nm;
        logic        wen;
        logic [31:0] wa;
        logic [31:0] ra;
        logic        rv;
        logic [15:0] fw;
        logic [15:0] fd;
        logic [15:0] fr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", nm, f, act, want);
        end
    endtask

    // Monitor: outputs are stable at the falling edge; compare against queued snapshots.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.nm, "wr_en",  {31'd0, wr_en},          {31'd0, e.wen});
                chk(e.nm, "wr_addr", wr_base_addr,           e.wa);
                chk(e.nm, "rd_addr", rd_base_addr,           e.ra);
                chk(e.nm, "rd_valid", {31'd0, rd_frame_valid}, {31'd0, e.rv});
                chk(e.nm, "written", {16'd0, frames_written}, {16'd0, e.fw});
                chk(e.nm, "dropped", {16'd0, frames_dropped}, {16'd0, e.fd});
                chk(e.nm, "repeated", {16'd0, frames_repeated}, {16'd0, e.fr});
                chk(e.nm, "repeated4", {28'd0, frames_repeated4}, {28'd0, e.fr[3:0]});
                chk(e.nm, "written4", {28'd0, frames_written4}, {28'd0, e.fw[3:0]});
            end
        end
    end

    task automatic cyc(input logic rst, input logic en, input logic wd, input logic rs);
        @(negedge clk);
        rst_n          = rst;
        enable         = en;
        wr_frame_done  = wd;
        rd_frame_start = rs;
        @(posedge clk);
        #1;
        wr_frame_done  = 1'b0;
        rd_frame_start = 1'b0;
    endtask

    task automatic expect_state(input string nm, input logic wen, input logic [31:0] wa,
                                input logic [31:0] ra, input logic rv,
                                input logic [15:0] fw, input logic [15:0] fd, input logic [15:0] fr);
        exp_t e;
        e.nm = nm; e.wen = wen; e.wa = wa; e.ra = ra; e.rv = rv;
        e.fw = fw; e.fd = fd; e.fr = fr;
        sb.push_back(e);
    endtask

    initial begin
        // Reset holds despite all inputs asserted.
        cyc(0, 1, 1, 1);
        cyc(0, 1, 1, 1);
        expect_state("reset",        0, 0,  S,  0, 0, 0, 0);
        cyc(1, 1, 0, 0); expect_state("arm",          1, 0,  S,  0, 0, 0, 0);
        cyc(1, 1, 1, 1); expect_state("discard",      1, 0,  S,  0, 0, 0, 0);
        cyc(1, 1, 1, 0); expect_state("wd1_lat",      1, 0,  S,  0, 1, 0, 0);
        cyc(1, 1, 0, 0); expect_state("wd1_addr",     1, S2, S,  0, 1, 0, 0);
        cyc(1, 1, 0, 1); expect_state("rs_lat",       1, S2, S,  1, 1, 0, 0);
        cyc(1, 1, 0, 0); expect_state("rs_addr",      1, S2, 0,  1, 1, 0, 0);
        cyc(1, 1, 0, 1); expect_state("repeat",       1, S2, 0,  1, 1, 0, 1);
        cyc(1, 1, 1, 0); expect_state("drop_a",       1, S2, 0,  1, 2, 0, 1);
        cyc(1, 1, 1, 0); expect_state("drop_b",       1, S,  0,  1, 3, 1, 1);
        cyc(1, 1, 1, 0); expect_state("drop_c",       1, S2, 0,  1, 4, 2, 1);
        cyc(1, 1, 0, 0); expect_state("drop_addr",    1, S,  0,  1, 4, 2, 1);
        cyc(1, 1, 1, 1); expect_state("both_v_lat",   1, S,  0,  1, 5, 3, 1);
        cyc(1, 1, 0, 0); expect_state("both_v_addr",  1, S2, S,  1, 5, 3, 1);
        cyc(1, 1, 1, 1); expect_state("both_nv_lat",  1, S2, S,  1, 6, 3, 1);
        cyc(1, 1, 0, 0); expect_state("both_nv_addr", 1, 0,  S2, 1, 6, 3, 1);
        cyc(1, 0, 1, 0); expect_state("disable",      0, 0,  S2, 0, 6, 3, 1);
        cyc(1, 0, 0, 1); expect_state("idle_ignore",  0, 0,  S2, 0, 6, 3, 1);
        cyc(1, 1, 0, 0); expect_state("rearm",        1, 0,  S2, 0, 6, 3, 1);
        cyc(1, 1, 1, 0); expect_state("rearm_discard",1, 0,  S2, 0, 6, 3, 1);
        cyc(1, 1, 0, 1); expect_state("rep_nofresh",  1, 0,  S2, 0, 6, 3, 2);
        for (int i = 0; i < 14; i++) cyc(1, 1, 0, 1);
        expect_state("wrap",         1, 0,  S2, 0, 6, 3, 16);
        cyc(0, 1, 1, 1); expect_state("mid_reset",    0, 0,  S,  0, 0, 0, 0);
        cyc(1, 0, 0, 0); expect_state("post_reset",   0, 0,  S,  0, 0, 0, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
